// File: rtl/pulse_cfg_ctrl_pkg.sv
// pulse_cfg_ctrl_pkg: shared state encoding, phase levels and index-width derivation
package pulse_cfg_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_BROWSE = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;
  localparam logic NS_ON  = 1'b1;
  localparam logic NS_OFF = 1'b0;
  function automatic int iw_of(input int csz);
    return $clog2(csz / 4);
  endfunction
endpackage

// File: rtl/pulse_cfg_ctrl_nibble_step.sv
// nibble_step: wraps one nibble of a vector by +1 or -1, leaving its neighbours untouched
module nibble_step #(
  parameter int CSZ = 64,
  parameter int IW  = 4
) (
  input  logic [CSZ-1:0] i_vec,
  input  logic [IW-1:0]  i_idx,
  input  logic           i_dn,
  output logic [CSZ-1:0] o_vec
);
  logic [3:0] w_nib;
  // replace the addressed nibble with its wrapped successor or predecessor
  always_comb begin
    o_vec = i_vec;
    w_nib = i_vec[{i_idx, 2'b00} +: 4];
    o_vec[{i_idx, 2'b00} +: 4] = i_dn ? w_nib - 4'd1 : w_nib + 4'd1;
  end
endmodule

// File: rtl/pulse_cfg_ctrl.sv
// pulse_cfg_ctrl: button-driven nibble editor for pulse limits with req/ack commit
module pulse_cfg_ctrl
  import pulse_cfg_ctrl_pkg::*;
#(
  parameter int          CSZ      = 64,
  parameter logic [63:0] DEF_UP   = 64'hFF,
  parameter logic [63:0] DEF_DOWN = 64'hFF
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  input  logic           i_next,
  input  logic           i_prev,
  input  logic           i_sel_phase,
  input  logic           i_mode,
  output logic           o_commit_req,
  input  logic           i_commit_ack,
  output logic [CSZ-1:0] o_lim_up,
  output logic [CSZ-1:0] o_lim_down,
  output logic [3:0]     o_disp_idx,
  output logic [3:0]     o_disp_val,
  output logic           o_phase_up,
  output logic           o_editing,
  output logic           o_busy
);
  localparam int IW = iw_of(CSZ);
  state_t         r_state, w_state_nx;
  logic [CSZ-1:0] r_sh_up, r_sh_down, r_act_up, r_act_down;
  logic [IW-1:0]  r_idx_up, r_idx_down;
  logic           r_phase;
  logic           w_ev_step, w_ev_sel, w_ev_mode, w_dirty, w_ack;
  logic [CSZ-1:0] w_vec, w_stepped, w_cl_up, w_cl_down;
  logic [IW-1:0]  w_idx, w_idx_nx;
  assign w_ev_step = i_next | i_prev;
  assign w_ev_sel  = !w_ev_step & i_sel_phase;
  assign w_ev_mode = !w_ev_step & !i_sel_phase & i_mode;
  assign w_dirty   = (r_sh_up != r_act_up) | (r_sh_down != r_act_down);
  assign w_ack     = (r_state == ST_COMMIT) & i_commit_ack;
  assign w_vec     = (r_phase == NS_ON) ? r_sh_up : r_sh_down;
  assign w_idx     = (r_phase == NS_ON) ? r_idx_up : r_idx_down;
  assign w_idx_nx  = i_next ? w_idx + IW'(1) : w_idx - IW'(1);
  assign w_cl_up   = (r_sh_up == '0) ? CSZ'(1) : r_sh_up;
  assign w_cl_down = (r_sh_down == '0) ? CSZ'(1) : r_sh_down;
  nibble_step #(.CSZ(CSZ), .IW(IW)) u_step (
    .i_vec(w_vec),
    .i_idx(w_idx),
    .i_dn (!i_next),
    .o_vec(w_stepped)
  );
  // state register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= ST_BROWSE;
    else r_state <= w_state_nx;
  end
  // next state and state-decoded outputs
  always_comb begin
    w_state_nx   = r_state;
    o_commit_req = 1'b0;
    o_busy       = 1'b0;
    o_editing    = 1'b0;
    if (r_state == ST_COMMIT) begin
      o_commit_req = 1'b1;
      o_busy       = 1'b1;
      w_state_nx   = i_commit_ack ? ST_BROWSE : ST_COMMIT;
    end else if (w_ev_mode) begin
      w_state_nx = (r_state == ST_BROWSE) ? ST_EDIT : (w_dirty ? ST_COMMIT : ST_BROWSE);
    end
    o_editing = (r_state == ST_EDIT);
  end
  // shadow, active, index and phase registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sh_up    <= DEF_UP[CSZ-1:0];
      r_sh_down  <= DEF_DOWN[CSZ-1:0];
      r_act_up   <= DEF_UP[CSZ-1:0];
      r_act_down <= DEF_DOWN[CSZ-1:0];
      r_idx_up   <= '0;
      r_idx_down <= '0;
      r_phase    <= NS_OFF;
    end else begin
      if (w_ack) begin
        r_act_up   <= w_cl_up;
        r_act_down <= w_cl_down;
        r_sh_up    <= w_cl_up;
        r_sh_down  <= w_cl_down;
      end
      if (r_state == ST_BROWSE && w_ev_step) begin
        if (r_phase == NS_ON) r_idx_up <= w_idx_nx;
        else r_idx_down <= w_idx_nx;
      end
      if (r_state == ST_EDIT && w_ev_step) begin
        if (r_phase == NS_ON) r_sh_up <= w_stepped;
        else r_sh_down <= w_stepped;
      end
      if (r_state != ST_COMMIT && w_ev_sel) r_phase <= (r_phase == NS_ON) ? NS_OFF : NS_ON;
    end
  end
  assign o_lim_up   = r_act_up;
  assign o_lim_down = r_act_down;
  assign o_phase_up = r_phase;
  assign o_disp_idx = 4'(w_idx);
  assign o_disp_val = w_vec[{w_idx, 2'b00} +: 4];
endmodule
